// File: rtl/btn_uart_tx.sv
// Turns debounced button pulses into ASCII characters, queues them and sends them as UART frames.
// Define BTN_UART_TX_PARITY_EN to add an even-parity bit before the stop bit (8E1 frame).
module btn_uart_tx #(
    parameter int unsigned BTN_WIDTH    = 5,
    parameter int unsigned CLKS_PER_BIT = 625,
    parameter int unsigned FIFO_AW      = 2,
    parameter logic [7:0]  CHAR_BASE    = 8'h30
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BTN_WIDTH-1:0] btn_pulse,
    output logic                 tx,
    output logic                 tx_busy,
    output logic [FIFO_AW:0]     fifo_count,
    output logic                 fifo_full
);
    localparam int unsigned DEPTH     = 1 << FIFO_AW;
    localparam int unsigned IW        = (BTN_WIDTH > 1) ? $clog2(BTN_WIDTH) : 1;
    localparam logic [15:0] BAUD_LOAD = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef BTN_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic [BTN_WIDTH-1:0] r_pending;
    logic [BTN_WIDTH-1:0] w_clr;
    logic [IW-1:0]        w_sel;
    logic [7:0]           w_char;
    logic                 w_wr;
    logic                 w_rd;

    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wptr;
    logic [FIFO_AW-1:0]   r_rptr;
    logic [FIFO_AW:0]     r_count;
    logic [FIFO_AW:0]     w_count_nxt;
    logic                 r_fifo_full;
    logic                 w_empty;
    logic [7:0]           w_head;

    logic [2:0]           r_state;
    logic [15:0]          r_baud;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 w_tick;
`ifdef BTN_UART_TX_PARITY_EN
    logic                 r_par;
`endif

    // Lowest-index pending button wins; scanning downward leaves the lowest set bit last.
    always_comb begin
        w_sel = '0;
        for (int i = BTN_WIDTH - 1; i >= 0; i--)
            if (r_pending[i]) w_sel = IW'(i);
    end

    assign w_wr   = (|r_pending) && !r_fifo_full;
    assign w_clr  = w_wr ? (BTN_WIDTH'(1) << w_sel) : '0;
    assign w_char = CHAR_BASE + 8'(w_sel);

    // A new pulse is OR-ed in after the clear so a same-cycle press is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pending <= '0;
        else      r_pending <= (r_pending & ~w_clr) | btn_pulse;
    end

    assign w_empty     = (r_count == '0);
    assign w_head      = r_mem[r_rptr];
    assign w_count_nxt = r_count + (FIFO_AW+1)'(w_wr) - (FIFO_AW+1)'(w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= w_char;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_fifo_full <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            r_count     <= w_count_nxt;
            r_fifo_full <= (w_count_nxt == (FIFO_AW+1)'(DEPTH));
        end
    end

    assign w_tick = (r_baud == 16'd0);
    // Pop from IDLE, or on the last stop-bit cycle to chain frames with no idle gap.
    assign w_rd   = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
`ifdef BTN_UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else if (r_state == S_IDLE) begin
            if (w_rd) begin
                r_shift <= w_head;
                r_baud  <= BAUD_LOAD;
                r_tx    <= 1'b0;
                r_state <= S_START;
`ifdef BTN_UART_TX_PARITY_EN
                r_par   <= ^w_head;
`endif
            end
        end else if (!w_tick) begin
            r_baud <= r_baud - 16'd1;
        end else begin
            r_baud <= BAUD_LOAD;
            case (r_state)
                S_START: begin
                    r_state <= S_DATA;
                    r_bit   <= 3'd0;
                    r_tx    <= r_shift[0];
                end
                S_DATA: begin
                    if (r_bit == 3'd7) begin
`ifdef BTN_UART_TX_PARITY_EN
                        r_state <= S_PARITY;
                        r_tx    <= r_par;
`else
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
`endif
                    end else begin
                        r_bit   <= r_bit + 3'd1;
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_tx    <= r_shift[1];
                    end
                end
`ifdef BTN_UART_TX_PARITY_EN
                S_PARITY: begin
                    r_state <= S_STOP;
                    r_tx    <= 1'b1;
                end
`endif
                default: begin
                    if (w_rd) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
`ifdef BTN_UART_TX_PARITY_EN
                        r_par   <= ^w_head;
`endif
                    end else begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                        r_baud  <= 16'd0;
                    end
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign tx_busy    = (r_state != S_IDLE);
    assign fifo_count = r_count;
    assign fifo_full  = r_fifo_full;
endmodule

// File: tb/tb_btn_uart_tx.sv
// Scoreboard bench for btn_uart_tx: stimulus pushes expected characters, a frame monitor decodes tx and compares.
// Six button inputs so six distinct presses can be queued against a four-entry FIFO.
module tb_btn_uart_tx;
    localparam int CPB = 4;
    localparam int BW  = 6;
    localparam int AW  = 2;
`ifdef BTN_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [BW-1:0] btn_pulse = '0;
    logic          tx;
    logic          tx_busy;
    logic [AW:0]   fifo_count;
    logic          fifo_full;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    btn_uart_tx #(
        .BTN_WIDTH   (BW),
        .CLKS_PER_BIT(CPB),
        .FIFO_AW     (AW),
        .CHAR_BASE   (8'h30)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pulse (btn_pulse),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .fifo_count(fifo_count),
        .fifo_full (fifo_full)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the sampling edge.
    task automatic pulse(input logic [BW-1:0] m);
        btn_pulse = m;
        @(negedge clk);
        btn_pulse = '0;
    endtask

    task automatic measure_busy(input string nm, input int exp);
        int n = 0;
        int t = 0;
        while (!tx_busy && t < 50) begin @(negedge clk); t++; end
        while (tx_busy && n < 1000) begin n++; @(negedge clk); end
        chk(nm, n, exp);
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while ((tx_busy || fifo_count != 0) && t < 3000) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        chk({nm, "_timeout"}, int'(tx_busy || fifo_count != 0), 0);
        chk({nm, "_sb_left"}, exp_q.size(), 0);
    endtask

    // Frame monitor: capture one sample per cycle from the start bit, decode and score.
    initial begin : monitor
        logic       s [FRAME];
        logic [7:0] got;
        logic [7:0] exp;
        int         hold_bad;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx === 1'b0) begin
                aborted = 1'b0;
                s[0] = tx;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge clk);
                    if (rst !== 1'b1) begin aborted = 1'b1; break; end
                    s[i] = tx;
                end
                if (!aborted) begin
                    hold_bad = 0;
                    for (int b = 0; b < NBITS; b++)
                        for (int j = 1; j < CPB; j++)
                            if (s[b*CPB+j] !== s[b*CPB]) hold_bad++;
                    for (int j = 0; j < 8; j++) got[j] = s[(j+1)*CPB];
                    chk("frame_hold", hold_bad, 0);
                    chk("stop_bit", int'(s[(NBITS-1)*CPB]), 1);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", int'(got), -1);
                    end else begin
                        exp = exp_q.pop_front();
                        chk("frame_char", int'(got), int'(exp));
`ifdef BTN_UART_TX_PARITY_EN
                        chk("parity_bit", int'(s[9*CPB]), int'(^exp));
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int bad;
        repeat (3) @(negedge clk);
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_full", int'(fifo_full), 0);
        rst = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== '0) bad++;
        end
        chk("idle50_bad", bad, 0);

        // Single press on button 2: latency and busy window
        exp_q.push_back(8'h32);
        pulse(6'b000100);
        chk("lat_k_tx", int'(tx), 1);
        chk("lat_k_cnt", int'(fifo_count), 0);
        @(negedge clk);
        chk("lat_k1_cnt", int'(fifo_count), 1);
        chk("lat_k1_tx", int'(tx), 1);
        @(negedge clk);
        chk("lat_k2_tx", int'(tx), 0);
        chk("lat_k2_cnt", int'(fifo_count), 0);
        measure_busy("single_busy", FRAME);
        wait_drain("single");

        // Three buttons in one cycle go out back-to-back, lowest first
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h31);
        exp_q.push_back(8'h34);
        pulse(6'b010011);
        measure_busy("b2b_busy", 3 * FRAME);
        wait_drain("b2b");

        // Fill the FIFO during a frame, then merge a repeat press on a pending bit
        exp_q.push_back(8'h30);
        pulse(6'b000001);
        repeat (8) @(negedge clk);
        chk("fill_pre_busy", int'(tx_busy), 1);
        exp_q.push_back(8'h35);
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h31);
        for (int b = BW - 1; b >= 0; b--) begin
            btn_pulse = BW'(1) << b;
            @(negedge clk);
        end
        btn_pulse = '0;
        chk("full_flag", int'(fifo_full), 1);
        chk("full_count", int'(fifo_count), 4);
        pulse(6'b000010);
        repeat (3) @(negedge clk);
        chk("merge_count", int'(fifo_count), 4);
        chk("merge_full", int'(fifo_full), 1);
        wait_drain("fill");

        // Asynchronous reset in the middle of a data bit that is low
        exp_q.push_back(8'h33);
        pulse(6'b001000);
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h34);
        pulse(6'b010000);
        repeat (9) @(negedge clk);
        chk("pre_rst_tx", int'(tx), 0);
        chk("pre_rst_count", int'(fifo_count), 1);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_tx", int'(tx), 1);
        chk("arst_count", int'(fifo_count), 0);
        chk("arst_busy", int'(tx_busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle_tx", int'(tx), 1);
        exp_q.push_back(8'h33);
        pulse(6'b001000);
        @(negedge clk);
        chk("post_rst_k1_tx", int'(tx), 1);
        @(negedge clk);
        chk("post_rst_k2_tx", int'(tx), 0);
        measure_busy("post_rst_busy", FRAME);
        wait_drain("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
